program_sequencer: RTL



---
 rtl/program_sequencer_pkg.sv | 22 ++
 rtl/program_sequencer_return_stack.sv | 61 ++++++
 rtl/program_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared sequencer/decoder definitions: fetch-address width,
// reset vector, sequencer state and the decoder's instruction word.
package defs;

  localparam int PM_ADDR_W = 8;

  localparam logic [PM_ADDR_W-1:0] RESET_VECTOR = 8'h00;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } seq_state_t;

  typedef logic [7:0] instruction_t;

  function automatic logic [PM_ADDR_W-1:0] jmp_target(
    input logic [3:0] nib
  );
    return {nib, 4'h0};
  endfunction

endpackage

// File: rtl/program_sequencer_return_stack.sv
// return_stack: parameterised LIFO of return addresses.
// Ports: clk, reset (async high), push, pop, din -> top, full, empty.
module return_stack
  import defs::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = PM_ADDR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);

  logic [SPW-1:0] sp_q, sp_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic [W-1:0]   mem_d [DEPTH];
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  rd_idx;
  logic [SPW-1:0] sp_dec;

  assign full   = (sp_q == SPW'(DEPTH));
  assign empty  = (sp_q == '0);
  assign sp_dec = sp_q - SPW'(1);
  // sp < DEPTH on a push and sp > 0 on a pop, so both
  // indices fit in AW bits whenever they are used.
  assign wr_idx = sp_q[AW-1:0];
  assign rd_idx = sp_dec[AW-1:0];
  assign top    = empty ? '0 : mem_q[rd_idx];

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (push && !full) begin
      mem_d[wr_idx] = din;
      sp_d          = sp_q + SPW'(1);
    end else if (pop && !empty) begin
      sp_d = sp_dec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: PC register, next-fetch mux, call/ret stack, fault FSM.
// In: clk, reset, jmp, jmp_nz, jmp_addr, dont_jmp, call, ret, hold.
// Out: pm_addr (comb), pc, stack_fault, from_PS (tied 0).
module program_sequencer
  import defs::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 jmp,
  input  logic                 jmp_nz,
  input  logic [3:0]           jmp_addr,
  input  logic                 dont_jmp,
  input  logic                 call,
  input  logic                 ret,
  input  logic                 hold,
  output logic [PM_ADDR_W-1:0] pm_addr,
  output logic [PM_ADDR_W-1:0] pc,
  output logic                 stack_fault,
  output logic [7:0]           from_PS
);

  logic [PM_ADDR_W-1:0] pc_q;
  logic [PM_ADDR_W-1:0] pc_inc;
  logic [PM_ADDR_W-1:0] target;
  logic [PM_ADDR_W-1:0] next_addr;
  logic [PM_ADDR_W-1:0] stk_top;
  seq_state_t           state_q, state_d;
  logic                 push, pop;
  logic                 stk_full, stk_empty;

  assign pc_inc = pc_q + PM_ADDR_W'(1);
  assign target = jmp_target(jmp_addr);

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    pop       = 1'b0;
    next_addr = pc_inc;
    if (state_q == FAULT) begin
      next_addr = pc_q;
    end else if (hold) begin
      next_addr = pc_q;
    end else if (ret) begin
      if (stk_empty) begin
        state_d   = FAULT;
        next_addr = pc_q;
      end else begin
        pop       = 1'b1;
        next_addr = stk_top;
      end
    end else if (call) begin
      if (stk_full) begin
        state_d   = FAULT;
        next_addr = pc_q;
      end else begin
        push      = 1'b1;
        next_addr = target;
      end
    end else if (jmp) begin
      next_addr = target;
    end else if (jmp_nz && !dont_jmp) begin
      next_addr = target;
    end
  end

  // Reset overrides the fetch address combinationally.
  assign pm_addr = reset ? RESET_VECTOR : next_addr;

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PM_ADDR_W)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      state_q <= RUN;
    end else begin
      pc_q    <= next_addr;
      state_q <= state_d;
    end
  end

  assign pc          = pc_q;
  assign stack_fault = (state_q == FAULT);
  assign from_PS     = 8'h00;

endmodule
